// File: rtl/axi_ring_writer.sv
// AXI4-Lite single-beat write responder feeding the unified-memory write port.
// Host writes to PUSH_ADDR append a word to a ring window at an auto-incrementing pointer.
module axi_ring_writer #(
  parameter logic [31:0] RING_BASE  = 32'hA0000100,
  parameter int          RING_BYTES = 256,
  parameter logic [31:0] PUSH_ADDR  = 32'hA0000000,
  parameter logic [31:0] MEM_LO     = 32'h00000000,
  parameter logic [31:0] MEM_HI     = 32'hA00001FC,
  localparam int         PTR_W      = $clog2(RING_BYTES)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_awvalid,
  output logic             s_awready,
  input  logic [31:0]      s_awaddr,
  input  logic             s_wvalid,
  output logic             s_wready,
  input  logic [31:0]      s_wdata,
  input  logic [3:0]       s_wstrb,
  output logic             s_bvalid,
  input  logic             s_bready,
  output logic [1:0]       s_bresp,
  output logic [31:0]      axi_mem_addr,
  output logic             axi_mem_w,
  output logic [31:0]      axi_mem_data,
  output logic [PTR_W-1:0] ring_ptr,
  output logic [15:0]      ring_wraps
);

  typedef enum logic [1:0] {IDLE, WRITE, RESP} state_e;

  state_e             state_q, state_d;
  logic               aw_held_q, aw_held_d;
  logic               w_held_q, w_held_d;
  logic [31:0]        awaddr_q, awaddr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [3:0]         wstrb_q, wstrb_d;
  logic               awready_q, awready_d;
  logic               wready_q, wready_d;
  logic               bvalid_q, bvalid_d;
  logic [1:0]         bresp_q, bresp_d;
  logic               mem_w_q, mem_w_d;
  logic [31:0]        mem_addr_q, mem_addr_d;
  logic [31:0]        mem_data_q, mem_data_d;
  logic [PTR_W-1:0]   ring_ptr_q, ring_ptr_d;
  logic [15:0]        ring_wraps_q, ring_wraps_d;

  logic               is_push, is_direct;
  logic [31:0]        addr_off;

  // Offset compare keeps the range check well-formed even when MEM_LO is zero.
  assign addr_off  = awaddr_q - MEM_LO;
  assign is_push   = (awaddr_q == PUSH_ADDR) && (wstrb_q == 4'hF);
  assign is_direct = (addr_off <= (MEM_HI - MEM_LO)) && (awaddr_q[1:0] == 2'b00) &&
                     (wstrb_q == 4'hF);

  always_comb begin
    state_d      = state_q;
    aw_held_d    = aw_held_q;
    w_held_d     = w_held_q;
    awaddr_d     = awaddr_q;
    wdata_d      = wdata_q;
    wstrb_d      = wstrb_q;
    awready_d    = awready_q;
    wready_d     = wready_q;
    bvalid_d     = bvalid_q;
    bresp_d      = bresp_q;
    mem_w_d      = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_data_d   = mem_data_q;
    ring_ptr_d   = ring_ptr_q;
    ring_wraps_d = ring_wraps_q;

    case (state_q)
      IDLE: begin
        if (awready_q && s_awvalid) begin
          aw_held_d = 1'b1;
          awaddr_d  = s_awaddr;
        end
        if (wready_q && s_wvalid) begin
          w_held_d = 1'b1;
          wdata_d  = s_wdata;
          wstrb_d  = s_wstrb;
        end
        awready_d = !aw_held_d;
        wready_d  = !w_held_d;
        if (aw_held_d && w_held_d) state_d = WRITE;
      end
      WRITE: begin
        if (is_push) begin
          mem_w_d    = 1'b1;
          mem_addr_d = RING_BASE + 32'(ring_ptr_q);
          mem_data_d = wdata_q;
          ring_ptr_d = ring_ptr_q + PTR_W'(4);
          if ((ring_ptr_q == PTR_W'(RING_BYTES - 4)) && (ring_wraps_q != 16'hFFFF))
            ring_wraps_d = ring_wraps_q + 16'd1;
        end else if (is_direct) begin
          mem_w_d    = 1'b1;
          mem_addr_d = awaddr_q;
          mem_data_d = wdata_q;
        end
        state_d = RESP;
      end
      RESP: begin
        // Held address/strobe are still valid here, so the response is decoded from them.
        if (!bvalid_q) begin
          bvalid_d = 1'b1;
          bresp_d  = (is_push || is_direct) ? 2'b00 : 2'b10;
        end else if (s_bready) begin
          bvalid_d  = 1'b0;
          awready_d = 1'b1;
          wready_d  = 1'b1;
          aw_held_d = 1'b0;
          w_held_d  = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      aw_held_q    <= 1'b0;
      w_held_q     <= 1'b0;
      awaddr_q     <= 32'h0;
      wdata_q      <= 32'h0;
      wstrb_q      <= 4'h0;
      awready_q    <= 1'b0;
      wready_q     <= 1'b0;
      bvalid_q     <= 1'b0;
      bresp_q      <= 2'b00;
      mem_w_q      <= 1'b0;
      mem_addr_q   <= 32'h0;
      mem_data_q   <= 32'h0;
      ring_ptr_q   <= '0;
      ring_wraps_q <= 16'h0;
    end else begin
      state_q      <= state_d;
      aw_held_q    <= aw_held_d;
      w_held_q     <= w_held_d;
      awaddr_q     <= awaddr_d;
      wdata_q      <= wdata_d;
      wstrb_q      <= wstrb_d;
      awready_q    <= awready_d;
      wready_q     <= wready_d;
      bvalid_q     <= bvalid_d;
      bresp_q      <= bresp_d;
      mem_w_q      <= mem_w_d;
      mem_addr_q   <= mem_addr_d;
      mem_data_q   <= mem_data_d;
      ring_ptr_q   <= ring_ptr_d;
      ring_wraps_q <= ring_wraps_d;
    end
  end

  assign s_awready    = awready_q;
  assign s_wready     = wready_q;
  assign s_bvalid     = bvalid_q;
  assign s_bresp      = bresp_q;
  assign axi_mem_w    = mem_w_q;
  assign axi_mem_addr = mem_addr_q;
  assign axi_mem_data = mem_data_q;
  assign ring_ptr     = ring_ptr_q;
  assign ring_wraps   = ring_wraps_q;

endmodule

// File: doc/axi_ring_writer.md
# axi_ring_writer

AXI4-Lite write responder that drives the `aximem` master side (`axi_mem_addr`, `axi_mem_w`, `axi_mem_data`) into the unified memory. It accepts single-beat host writes and converts each into one full-word memory write pulse. Writes to a dedicated push address go into the 256-byte ring window at `32'hA0000100`–`32'hA00001FF`, at a hardware-managed, auto-incrementing pointer. All other legal addresses are written directly.

## Interface
Parameters:
- `RING_BASE`, `32'hA0000100`, byte address of ring slot 0.
- `RING_BYTES`, `256`, ring size in bytes; a power of two, multiple of 4.
- `PUSH_ADDR`, `32'hA0000000`, host address that appends one word to the ring.
- `MEM_LO`, `32'h00000000`, lowest legal direct-write address.
- `MEM_HI`, `32'hA00001FC`, highest legal direct-write address; inclusive, word aligned.

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  reset: synchronous, active-low.
- `s_awvalid`  in  1  write-address valid.
- `s_awready`  out  1  write-address ready.
- `s_awaddr`  in  32  write byte address.
- `s_wvalid`  in  1  write-data valid.
- `s_wready`  out  1  write-data ready.
- `s_wdata`  in  32  write data, little-endian.
- `s_wstrb`  in  4  byte strobes.
- `s_bvalid`  out  1  response valid.
- `s_bready`  in  1  response ready.
- `s_bresp`  out  2  response: `2'b00` = OKAY, `2'b10` = SLVERR.
- `axi_mem_addr`  out  32  memory byte address.
- `axi_mem_w`  out  1  one-cycle write strobe.
- `axi_mem_data`  out  32  memory write word.
- `ring_ptr`  out  8  current ring byte offset; `log2(RING_BYTES)` bits, always a multiple of 4.
- `ring_wraps`  out  16  count of ring wrap-arounds; saturates at `16'hFFFF`.

## Operation
- **FSM states:** IDLE, WRITE, RESP.
- **IDLE: address and data capture.**
  - AW and W are captured independently, in either order or in the same cycle.
  - Each ready is 1 while its channel is not yet held. It drops to 0 the cycle after capture.
  - When both are held, the FSM goes to WRITE.
- **Decode,** computed from the held address and strobes:
  - **PUSH:** `awaddr == PUSH_ADDR` and `wstrb == 4'hF`.
  - **DIRECT:** `MEM_LO <= awaddr <= MEM_HI` and `awaddr[1:0] == 0` and `wstrb == 4'hF`.
  - **ERR:** anything else.
- **WRITE: exactly one cycle.**
  - PUSH: `axi_mem_w = 1`, `axi_mem_addr = RING_BASE + ring_ptr`, `axi_mem_data = wdata`. Then `ring_ptr <= (ring_ptr + 4) mod RING_BYTES`. If the old `ring_ptr == RING_BYTES-4`, `ring_wraps` increments (saturating).
  - DIRECT: `axi_mem_w = 1`, `axi_mem_addr = awaddr`, `axi_mem_data = wdata`. `ring_ptr` is unchanged, even when the address is inside the ring window.
  - ERR: `axi_mem_w` stays 0 and no state changes.
  - All cases go to RESP.
- **RESP:**
  - `s_bvalid = 1`; `s_bresp` is OKAY for PUSH/DIRECT and SLVERR for ERR.
  - `s_bvalid` and `s_bresp` stay stable until `s_bready`.
  - On the handshake cycle: `s_bvalid <= 0`, both readies `<= 1`, FSM goes to IDLE.
- **Ring arithmetic:**
  - Pointer adds are modulo `RING_BYTES`; memory addresses are never formed past `RING_BASE + RING_BYTES - 4`.
  - A pushed word never straddles the wrap, so the memory side needs no split-address handling.
- **No outstanding depth:** a new AW/W is not accepted until B completes.

## Timing
- **Reset (`rst_n` = 0 at a `clk` edge):**
  - `s_awready = 0`, `s_wready = 0`, `s_bvalid = 0`, `s_bresp = 0`.
  - `axi_mem_w = 0`, `axi_mem_addr = 0`, `axi_mem_data = 0`.
  - `ring_ptr = 0`, `ring_wraps = 0`; FSM goes to IDLE; held AW/W are discarded.
- **After reset:** readies go to 1 on the first edge with `rst_n = 1`.
- **Latency, AW and W handshaked at edge N:**
  - `axi_mem_w` is high for the cycle after N, i.e. registered and visible between edges N+1 and N+2.
  - `s_bvalid` rises at edge N+2.
  - Minimum 3 cycles per transaction with `s_bready` held high.
- **Staggered channels:** AW at edge N and W at edge N+k gives WRITE after N+k.
- **Memory-side outputs:**
  - `axi_mem_addr` and `axi_mem_data` hold their last value when `axi_mem_w = 0`.
  - `axi_mem_w` is never high for 2 consecutive cycles.
- **Reset mid-transaction:**
  - Reset during WRITE suppresses the pulse if asserted at that edge.
  - Reset during RESP drops `s_bvalid` with no response delivered.
  - Host retry is the host's responsibility.
- **`s_bready` held low:** the FSM stalls in RESP indefinitely and both readies stay 0.

## Test plan
- Reset, then a DIRECT write of `0xDEADBEEF` to `0x00000040` with AW and W together. Required: `axi_mem_w` pulse of 1 cycle, `addr = 0x40`, `data = 0xDEADBEEF`; `s_bvalid` 2 cycles after the handshake with OKAY.
- 65 PUSH writes of data `i = 0..64`. Required: addresses `0xA0000100`, `0xA0000104`, …, `0xA00001FC`, then `0xA0000100` for `i = 64`; `ring_ptr = 4` and `ring_wraps = 1` at the end.
- W sent 3 cycles before AW (PUSH). Required: `s_wready` low after W capture, write occurs only after AW, `ring_ptr` advances by 4.
- Errors: `wstrb = 4'h3` to `0x40`, unaligned `0x41`, and `0xA0000200`. Required: each gives SLVERR, no `axi_mem_w` pulse, `ring_ptr` unchanged.
- `s_bready` held low 10 cycles after a PUSH. Required: `s_bvalid` and `s_bresp` stable and readies 0 throughout; completes on the `s_bready` cycle.
- `rst_n` asserted while in RESP after 5 pushes. Required: `s_bvalid = 0`, `ring_ptr = 0`, `ring_wraps = 0`; the next PUSH goes to `0xA0000100`.
